// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the MIPS core front end.
//   - XLEN / INSN_BYTES      : datapath width and instruction size in bytes
//   - RESET_VECTOR_DEFAULT   : default PC loaded while reset is asserted
//   - fetch_entry_t          : {pc, instr} pair carried from fetch to decode
//   - pc_plus_insn()         : sequential next-PC, wraps modulo 2^XLEN
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int XLEN       = 32;
    localparam int INSN_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Carry out of bit XLEN-1 is dropped, so the top word wraps to 0.
    function automatic logic [XLEN-1:0] pc_plus_insn(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSN_BYTES);
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// -----------------------------------------------------------------------------
// ifetch_fifo
//   DEPTH-entry synchronous FIFO used twice by the fetch unit: as the
//   instruction buffer (entry_t = fetch_entry_t) and as the in-flight
//   address queue (entry_t = a bare address).
//
//   Ports
//     clk, rst    clock, asynchronous active-high reset
//     push        write push_data at the tail (ignored when full unless a pop
//                 frees a slot in the same cycle)
//     push_data   entry to write
//     pop         drop the head entry (ignored when empty)
//     flush       empty the FIFO; wins over push and pop
//     head        current head entry (meaningful only when count != 0)
//     count       number of valid entries, 0..DEPTH
//
//   DEPTH must be a power of two and at least 2 so the pointers wrap freely.
// -----------------------------------------------------------------------------
module ifetch_fifo
    import mips_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    input  logic                   flush,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
        end
    end

    // NOTE: the storage array has no reset; count alone says which slots are
    // valid, so clearing the data would only cost a reset net per bit.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit
//   Read side of the program counter. Issues word fetches at pc over a
//   request/grant/response memory interface, buffers returned words with
//   their addresses for decode, and computes the PC register's next value.
//
//   Parameters
//     DEPTH         fetches in flight plus buffered instructions (pow2, >= 2)
//     RESET_VECTOR  value driven on next_pc while rst is asserted
//
//   Ports
//     clk, rst                     clock, asynchronous active-high reset
//     pc / next_pc                 PC register output / input
//     redirect, redirect_pc        flush and refetch from redirect_pc
//     imem_req, imem_addr          fetch request at byte address pc
//     imem_gnt                     request accepted this cycle
//     imem_rvalid, imem_rdata      in-order response
//     if_valid, if_instr, if_pc    buffered instruction to decode
//     id_ready                     decode takes the head this cycle
// -----------------------------------------------------------------------------
module ifetch_unit
    import mips_pkg::*;
#(
    parameter int              DEPTH        = 2,
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            id_ready
);

    // Counter width that can hold 0..DEPTH.
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]   inflight;      // granted, response not yet seen
    logic [CW-1:0]   kill;          // oldest responses still owed that are stale
    logic [CW-1:0]   occupancy;     // instruction FIFO entries
    logic [CW-1:0]   aq_count;      // address queue entries, tracks inflight
    logic [CW:0]     used;

    logic            credit;
    logic            grant;
    logic            resp;
    logic            kill_resp;

    logic [XLEN-1:0] aq_head;
    fetch_entry_t    fifo_in;
    fetch_entry_t    fifo_head;

    // ------------------------------------------------------------------
    // Credit and request. Occupancy is registered, so id_ready never
    // reaches imem_req combinationally; a slot freed by decode this cycle
    // is offered to memory next cycle.
    // ------------------------------------------------------------------
    assign used     = {1'b0, inflight} + {1'b0, occupancy};
    assign credit   = used < (CW + 1)'(DEPTH);
    assign imem_req = credit && !redirect && !rst;
    assign imem_addr = pc;
    assign grant    = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol error: drop it.
    assign resp      = imem_rvalid && (inflight != '0);
    assign kill_resp = resp && (kill != '0);

    // ------------------------------------------------------------------
    // Next PC: reset, then redirect, then sequential advance on grant.
    // ------------------------------------------------------------------
    // NOTE: every branch assigns next_pc, so this stays combinational with
    // no inferred latch even without a separate default assignment.
    always_comb begin
        if (rst)           next_pc = RESET_VECTOR;
        else if (redirect) next_pc = redirect_pc;
        else if (grant)    next_pc = pc_plus_insn(pc);
        else               next_pc = pc;
    end

    // ------------------------------------------------------------------
    // Outstanding-fetch bookkeeping. On redirect every fetch still owed
    // becomes stale; the one answered this very cycle is already gone.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
            kill     <= '0;
        end else begin
            inflight <= inflight + CW'(grant) - CW'(resp);
            if (redirect)
                kill <= inflight - CW'(resp);
            else if (kill_resp)
                kill <= kill - CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Address queue: one entry per outstanding fetch, oldest at the head.
    // After a redirect every remaining entry belongs to a killed fetch and
    // is popped by its own (discarded) response, so the queue never needs
    // flushing and stays paired with kill.
    // ------------------------------------------------------------------
    ifetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (logic [XLEN-1:0])
    ) u_addr_q (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .push_data (pc),
        .pop       (resp),
        .flush     (1'b0),
        .head      (aq_head),
        .count     (aq_count)
    );

    // ------------------------------------------------------------------
    // Instruction FIFO. The flush on redirect beats both the push of a
    // same-cycle response and any pop by decode.
    // ------------------------------------------------------------------
    assign fifo_in = '{pc: aq_head, instr: imem_rdata};

    ifetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_insn_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (resp && !kill_resp && !redirect),
        .push_data (fifo_in),
        .pop       (if_valid && id_ready),
        .flush     (redirect),
        .head      (fifo_head),
        .count     (occupancy)
    );

    // Outputs read 0 whenever nothing is buffered, which covers reset.
    assign if_valid = (occupancy != '0);
    assign if_instr = if_valid ? fifo_head.instr : '0;
    assign if_pc    = if_valid ? fifo_head.pc    : '0;

    // The address queue and the inflight counter describe the same set of
    // fetches; kill can never exceed it.
    a_aq_pairs_inflight : assert property (
        @(posedge clk) disable iff (rst) (aq_count == inflight) && (kill <= inflight)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// -----------------------------------------------------------------------------
// tb_ifetch_unit
//   Directed cycle tables for the fetch unit's main sequences, hand-written
//   wrap and asynchronous-reset sequences, then randomized traffic compared
//   against a queue-based model of outstanding fetches and buffered words.
// -----------------------------------------------------------------------------
module tb_ifetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RV    = 32'h0000_0200;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    // PC register owned by the bench, with a load port for directed tests.
    logic        pc_force;
    logic [31:0] pc_force_val;

    int n_checks = 0;
    int n_fail   = 0;

    ifetch_unit #(
        .DEPTH        (DEPTH),
        .RESET_VECTOR (RV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .next_pc     (next_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) pc <= pc_force ? pc_force_val : next_pc;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[31:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed cycle table
    // ------------------------------------------------------------------
    typedef struct {
        string       tag;
        logic        gnt;
        logic        rv;
        logic [31:0] raddr;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        ereq;
        logic [31:0] enext;
        logic        evalid;
        logic [31:0] eipc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string tag, input logic gnt, input logic rv,
                                input logic [31:0] raddr, input logic rdy,
                                input logic redir, input logic [31:0] rpc,
                                input logic ereq, input logic [31:0] enext,
                                input logic evalid, input logic [31:0] eipc);
        vecs.push_back('{tag, gnt, rv, raddr, rdy, redir, rpc, ereq, enext, evalid, eipc});
    endfunction

    task automatic apply(input vec_t v, input int idx);
        imem_gnt    = v.gnt;
        imem_rvalid = v.rv;
        imem_rdata  = v.rv ? instr_of(v.raddr) : 32'h0;
        id_ready    = v.rdy;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        #1;
        check($sformatf("%s[%0d].imem_req", v.tag, idx), 32'(imem_req), 32'(v.ereq));
        check($sformatf("%s[%0d].next_pc",  v.tag, idx), next_pc, v.enext);
        check($sformatf("%s[%0d].if_valid", v.tag, idx), 32'(if_valid), 32'(v.evalid));
        if (v.evalid) begin
            check($sformatf("%s[%0d].if_pc",    v.tag, idx), if_pc, v.eipc);
            check($sformatf("%s[%0d].if_instr", v.tag, idx), if_instr, instr_of(v.eipc));
        end
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model for random traffic: outstanding fetches in order,
    // each flagged stale once a redirect has overtaken it, plus the list
    // of words waiting for decode.
    // ------------------------------------------------------------------
    typedef struct { logic [31:0] addr; bit stale; } owed_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    owed_t owed[$];
    ent_t  mfifo[$];
    mreq_t mq[$];

    initial begin
        rst          = 1'b1;
        pc_force     = 1'b1;
        pc_force_val = 32'h0000_0100;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        id_ready     = 1'b0;

        // Sequential fetch from 0x100 with 1-cycle responses.
        add("seq", 1, 0, 32'h000, 1, 0, 32'h0, 1, 32'h104, 0, 32'h000);
        add("seq", 1, 1, 32'h100, 1, 0, 32'h0, 1, 32'h108, 0, 32'h000);
        add("seq", 1, 1, 32'h104, 1, 0, 32'h0, 0, 32'h108, 1, 32'h100);
        add("seq", 1, 0, 32'h000, 1, 0, 32'h0, 1, 32'h10C, 1, 32'h104);
        add("seq", 1, 1, 32'h108, 1, 0, 32'h0, 1, 32'h110, 0, 32'h000);
        add("seq", 1, 1, 32'h10C, 1, 0, 32'h0, 0, 32'h110, 1, 32'h108);
        add("seq", 0, 0, 32'h000, 1, 0, 32'h0, 1, 32'h110, 1, 32'h10C);
        add("seq", 0, 0, 32'h000, 1, 0, 32'h0, 1, 32'h110, 0, 32'h000);
        // Backpressure: exactly DEPTH grants, then hold, then in-order drain.
        add("bp",  1, 0, 32'h000, 0, 0, 32'h0, 1, 32'h114, 0, 32'h000);
        add("bp",  1, 1, 32'h110, 0, 0, 32'h0, 1, 32'h118, 0, 32'h000);
        add("bp",  1, 1, 32'h114, 0, 0, 32'h0, 0, 32'h118, 1, 32'h110);
        add("bp",  1, 0, 32'h000, 0, 0, 32'h0, 0, 32'h118, 1, 32'h110);
        add("bp",  1, 0, 32'h000, 0, 0, 32'h0, 0, 32'h118, 1, 32'h110);
        add("bp",  0, 0, 32'h000, 1, 0, 32'h0, 0, 32'h118, 1, 32'h110);
        add("bp",  0, 0, 32'h000, 1, 0, 32'h0, 1, 32'h118, 1, 32'h114);
        add("bp",  0, 0, 32'h000, 0, 0, 32'h0, 1, 32'h118, 0, 32'h000);
        // Redirect to 0x400 with two fetches in flight: both answers dropped.
        add("rdr", 1, 0, 32'h000, 1, 0, 32'h000, 1, 32'h11C, 0, 32'h000);
        add("rdr", 1, 0, 32'h000, 1, 0, 32'h000, 1, 32'h120, 0, 32'h000);
        add("rdr", 1, 0, 32'h000, 1, 1, 32'h400, 0, 32'h400, 0, 32'h000);
        add("rdr", 1, 1, 32'h118, 1, 0, 32'h000, 0, 32'h400, 0, 32'h000);
        add("rdr", 1, 1, 32'h11C, 1, 0, 32'h000, 1, 32'h404, 0, 32'h000);
        add("rdr", 0, 1, 32'h400, 0, 0, 32'h000, 1, 32'h404, 0, 32'h000);
        add("rdr", 0, 0, 32'h000, 0, 0, 32'h000, 1, 32'h404, 1, 32'h400);
        add("rdr", 0, 0, 32'h000, 1, 0, 32'h000, 1, 32'h404, 1, 32'h400);
        add("rdr", 0, 0, 32'h000, 1, 0, 32'h000, 1, 32'h404, 0, 32'h000);
        // Redirect together with a response and a pop: one owed, none killed.
        add("rrp", 1, 0, 32'h000, 0, 0, 32'h000, 1, 32'h408, 0, 32'h000);
        add("rrp", 1, 1, 32'h404, 0, 0, 32'h000, 1, 32'h40C, 0, 32'h000);
        add("rrp", 0, 0, 32'h000, 0, 0, 32'h000, 0, 32'h40C, 1, 32'h404);
        add("rrp", 1, 1, 32'h408, 1, 1, 32'h800, 0, 32'h800, 1, 32'h404);
        add("rrp", 1, 0, 32'h000, 1, 0, 32'h000, 1, 32'h804, 0, 32'h000);
        add("rrp", 0, 1, 32'h800, 1, 0, 32'h000, 1, 32'h804, 0, 32'h000);
        add("rrp", 0, 0, 32'h000, 1, 0, 32'h000, 1, 32'h804, 1, 32'h800);
        add("rrp", 0, 0, 32'h000, 1, 0, 32'h000, 1, 32'h804, 0, 32'h000);

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst.imem_req",  32'(imem_req), 32'h0);
        check("rst.if_valid",  32'(if_valid), 32'h0);
        check("rst.next_pc",   next_pc, RV);
        check("rst.imem_addr", imem_addr, 32'h0000_0100);
        check("rst.if_pc",     if_pc, 32'h0);
        check("rst.if_instr",  if_instr, 32'h0);
        rst      = 1'b0;
        pc_force = 1'b0;

        // ---------------- table ----------------
        foreach (vecs[i]) apply(vecs[i], i);
        redirect = 1'b0;

        // ---------------- wrap at the top of the address space ----------------
        imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
        pc_force = 1'b1; pc_force_val = 32'hFFFF_FFFC;
        step();
        pc_force = 1'b0;
        imem_gnt = 1'b1;
        #1;
        check("wrap.imem_req",  32'(imem_req), 32'h1);
        check("wrap.imem_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap.next_pc",   next_pc, 32'h0);
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr_of(32'hFFFF_FFFC);
        #1;
        check("wrap.pc_after", next_pc, 32'h0);
        step();
        imem_rvalid = 1'b0; id_ready = 1'b1;
        #1;
        check("wrap.if_valid", 32'(if_valid), 32'h1);
        check("wrap.if_pc",    if_pc, 32'hFFFF_FFFC);
        check("wrap.if_instr", if_instr, instr_of(32'hFFFF_FFFC));
        step();
        id_ready = 1'b0;

        // ---------------- asynchronous reset mid-stream ----------------
        imem_gnt = 1'b1;                        // fetch at 0
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr_of(32'h0);
        step();
        imem_rvalid = 1'b0;
        #1;
        check("arst.pre_req",   32'(imem_req), 32'h1);
        check("arst.pre_valid", 32'(if_valid), 32'h1);
        check("arst.pre_if_pc", if_pc, 32'h0);
        #1;
        rst = 1'b1;                             // between clock edges
        #1;
        check("arst.imem_req",  32'(imem_req), 32'h0);
        check("arst.if_valid",  32'(if_valid), 32'h0);
        check("arst.next_pc",   next_pc, RV);
        check("arst.imem_addr", imem_addr, 32'h0000_0004);
        check("arst.if_pc",     if_pc, 32'h0);
        check("arst.if_instr",  if_instr, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        step();
        imem_gnt = 1'b1;
        #1;
        check("arst.resume_req",  32'(imem_req), 32'h1);
        check("arst.resume_addr", imem_addr, RV);
        check("arst.resume_next", next_pc, RV + 32'd4);
        check("arst.resume_nv",   32'(if_valid), 32'h0);
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr_of(RV); id_ready = 1'b1;
        step();
        imem_rvalid = 1'b0;
        #1;
        check("arst.resume_valid", 32'(if_valid), 32'h1);
        check("arst.resume_if_pc", if_pc, RV);
        check("arst.resume_instr", if_instr, instr_of(RV));
        step();

        // ---------------- randomized traffic against the model ----------------
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0; redirect = 1'b0;
        step();
        rst = 1'b0;
        owed.delete(); mfifo.delete(); mq.delete();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit          rsp;
            bit          ereq;
            logic [31:0] enext;
            owed_t       o;

            imem_gnt    = ($urandom_range(0, 3) != 0);
            id_ready    = ($urandom_range(0, 4) < 3);
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            rsp         = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            if (mq.size() != 0 && mq[0].due <= cyc && $urandom_range(0, 3) != 0) begin
                rsp         = 1'b1;
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(mq[0].addr);
            end else if (mq.size() == 0 && $urandom_range(0, 7) == 0) begin
                imem_rvalid = 1'b1;             // stray response, must be ignored
                imem_rdata  = $urandom;
            end
            #1;

            ereq  = ((owed.size() + mfifo.size()) < DEPTH) && !redirect;
            enext = redirect ? redirect_pc : (ereq && imem_gnt) ? pc + 32'd4 : pc;
            check("rnd.imem_req",  32'(imem_req), 32'(ereq));
            check("rnd.next_pc",   next_pc, enext);
            check("rnd.imem_addr", imem_addr, pc);
            check("rnd.if_valid",  32'(if_valid), 32'(mfifo.size() != 0));
            if (mfifo.size() != 0) begin
                check("rnd.if_pc",    if_pc, mfifo[0].pc);
                check("rnd.if_instr", if_instr, mfifo[0].instr);
            end

            // memory side follows the DUT's actual handshake
            if (rsp) void'(mq.pop_front());
            if (imem_req && imem_gnt)
                mq.push_back('{imem_addr, cyc + int'($urandom_range(1, 3))});

            // model state for the coming edge
            if (mfifo.size() != 0 && id_ready && !redirect) void'(mfifo.pop_front());
            if (rsp && owed.size() != 0) begin
                o = owed.pop_front();
                if (!o.stale && !redirect) mfifo.push_back('{o.addr, imem_rdata});
            end
            if (redirect) begin
                mfifo.delete();
                foreach (owed[i]) owed[i].stale = 1'b1;
            end
            if (ereq && imem_gnt) owed.push_back('{pc, 1'b0});

            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
